dual_port_sync_sram: RTL

DUAL_PORT_SYNC_SRAM -- requirements
Module: dual_port_sync_sram

---
 rtl/dual_port_sync_sram.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dual_port_sync_sram.sv
// ---------------------------------------------------------------------------
// dual_port_sync_sram
//
// True dual-port synchronous SRAM with byte-enabled writes, a configurable
// read latency and same-address conflict reporting. Both ports share one
// clock and each port can issue one read or one write every cycle.
//
// Timing: a read request sampled at edge N captures the array contents at
// that same edge. The captured {valid, data} pair then moves through a
// READ_LATENCY-deep shift pipeline, so rvalid and rdata change at edge
// N+READ_LATENCY. rdata holds its last delivered word between pulses.
//
// Parameters
//   ADDR_WIDTH    address bits per port, depth is 2**ADDR_WIDTH words
//   DATA_WIDTH    word width, multiple of 8
//   READ_LATENCY  edges from read issue to rvalid, 1..3
//   WRITE_FIRST   same-port read-during-write selection, reserved (0 or 1)
//
// Ports
//   clk_i                 single clock, rising edge
//   rst_i                 synchronous active-high reset (memory is kept)
//   a_req_i / b_req_i     request valid
//   a_we_i / b_we_i       1 = write, 0 = read
//   a_be_i / b_be_i       byte enables for writes
//   a_addr_i / b_addr_i   word address
//   a_wdata_i / b_wdata_i write data
//   a_rdata_o / b_rdata_o read data, meaningful while rvalid is high
//   a_rvalid_o/b_rvalid_o one pulse per accepted read
//   collision_o           one-cycle pulse for a same-address conflict
// ---------------------------------------------------------------------------
module dual_port_sync_sram #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    a_req_i,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    output logic                    a_rvalid_o,

    input  logic                    b_req_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,
    output logic                    b_rvalid_o,

    output logic                    collision_o
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Reject configurations the pipeline and byte lanes cannot support.
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
        $fatal(1, "dual_port_sync_sram: READ_LATENCY must be 1..3, got %0d", READ_LATENCY);
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $fatal(1, "dual_port_sync_sram: DATA_WIDTH must be a multiple of 8, got %0d", DATA_WIDTH);
    end
    if (WRITE_FIRST != 0 && WRITE_FIRST != 1) begin : g_bad_write_first
        $fatal(1, "dual_port_sync_sram: WRITE_FIRST must be 0 or 1, got %0d", WRITE_FIRST);
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_a_wr;
    logic                  w_b_wr;
    logic                  w_a_wr_eff;
    logic                  w_b_wr_eff;
    logic                  w_same_addr;
    logic                  w_conflict;
    logic [NUM_BYTES-1:0]  w_b_be_eff;

    logic                  w_rd     [2];
    logic [ADDR_WIDTH-1:0] w_raddr  [2];
    logic                  w_rvalid [2];
    logic [DATA_WIDTH-1:0] w_rdata  [2];

    logic                  r_conflict_seen;
    logic                  r_collision;

    assign w_a_wr      = a_req_i & a_we_i;
    assign w_b_wr      = b_req_i & b_we_i;
    assign w_same_addr = (a_addr_i == b_addr_i);

    // A write with no byte enabled changes nothing, so it cannot conflict.
    assign w_a_wr_eff  = w_a_wr & (|a_be_i);
    assign w_b_wr_eff  = w_b_wr & (|b_be_i);

    // Any same-address pair involving at least one real write is a conflict;
    // two reads of one word are harmless.
    assign w_conflict  = a_req_i & b_req_i & w_same_addr & (w_a_wr_eff | w_b_wr_eff);

    // On a same-address double write port A owns every byte it enables;
    // port B only lands in the bytes A leaves alone.
    assign w_b_be_eff  = (w_a_wr && w_same_addr) ? (b_be_i & ~a_be_i) : b_be_i;

    assign w_rd[0]     = a_req_i & ~a_we_i;
    assign w_rd[1]     = b_req_i & ~b_we_i;
    assign w_raddr[0]  = a_addr_i;
    assign w_raddr[1]  = b_addr_i;

    // Byte-lane writes. Memory is deliberately not cleared by reset, but
    // requests presented during reset are dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_a_wr && a_be_i[i]) begin
                    r_mem[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
                end
                if (w_b_wr && w_b_be_eff[i]) begin
                    r_mem[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Per-port read path. Stage 0 captures the array at the issuing edge, so
    // later writes cannot disturb a read already in flight. Data only moves
    // along with a valid bit, which makes the last stage hold its previous
    // word between pulses.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [READ_LATENCY:0] r_vld;
        logic [DATA_WIDTH-1:0] r_data [READ_LATENCY+1];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_vld <= '0;
                for (int k = 0; k <= READ_LATENCY; k++) begin
                    r_data[k] <= '0;
                end
            end else begin
                r_vld[0] <= w_rd[p];
                if (w_rd[p]) begin
                    r_data[0] <= r_mem[w_raddr[p]];
                end
                for (int k = 1; k <= READ_LATENCY; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end

        assign w_rvalid[p] = r_vld[READ_LATENCY];
        assign w_rdata[p]  = r_data[READ_LATENCY];
    end

    // The conflict is noted at the edge that samples it and reported on the
    // following edge as a single-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_conflict_seen <= 1'b0;
            r_collision     <= 1'b0;
        end else begin
            r_conflict_seen <= w_conflict;
            r_collision     <= r_conflict_seen;
        end
    end

    assign a_rvalid_o  = w_rvalid[0];
    assign a_rdata_o   = w_rdata[0];
    assign b_rvalid_o  = w_rvalid[1];
    assign b_rdata_o   = w_rdata[1];
    assign collision_o = r_collision;

endmodule
